// File: rtl/sound_pkg.sv
// Shared definitions for the sound scheduler: sound IDs, FSM states and
// the priority helpers used to pick and compare sounds.
package sound_pkg;

  typedef logic [2:0] sound_id_t;

  localparam sound_id_t SND_NONE     = 3'd0;
  localparam sound_id_t SND_CHOMP    = 3'd1;
  localparam sound_id_t SND_PLACE    = 3'd2;
  localparam sound_id_t SND_TRAVEL   = 3'd3;
  localparam sound_id_t SND_MOVE     = 3'd4;
  localparam sound_id_t SND_GAMEOVER = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_PLAYING,
    ST_GAP
  } state_t;

  // Larger rank wins; SND_NONE ranks below every real sound.
  function automatic logic [2:0] sound_rank(input sound_id_t id);
    case (id)
      SND_GAMEOVER: sound_rank = 3'd5;
      SND_TRAVEL:   sound_rank = 3'd4;
      SND_PLACE:    sound_rank = 3'd3;
      SND_CHOMP:    sound_rank = 3'd2;
      SND_MOVE:     sound_rank = 3'd1;
      default:      sound_rank = 3'd0;
    endcase
  endfunction

  // Highest-priority sound present in a pending set (bit i = sound i+1).
  function automatic sound_id_t highest_pending(input logic [4:0] p);
    if (p[4])      highest_pending = SND_GAMEOVER;
    else if (p[2]) highest_pending = SND_TRAVEL;
    else if (p[1]) highest_pending = SND_PLACE;
    else if (p[0]) highest_pending = SND_CHOMP;
    else if (p[3]) highest_pending = SND_MOVE;
    else           highest_pending = SND_NONE;
  endfunction

  // Pending-set bit that belongs to a sound ID.
  function automatic logic [4:0] sound_mask(input sound_id_t id);
    case (id)
      SND_CHOMP:    sound_mask = 5'b00001;
      SND_PLACE:    sound_mask = 5'b00010;
      SND_TRAVEL:   sound_mask = 5'b00100;
      SND_MOVE:     sound_mask = 5'b01000;
      SND_GAMEOVER: sound_mask = 5'b10000;
      default:      sound_mask = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable 32-bit down-counter; parks at zero instead of wrapping.
module sound_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        en,
  output logic        zero
);

  logic [31:0] count_q;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      count_q <= 32'd0;
    end else if (load) begin
      count_q <= value;
    end else if (en && (count_q != 32'd0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign zero = (count_q == 32'd0);

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates sound requests onto one audio player: pending set, priority
// launch with preemption, per-sound duration and an inter-sound gap.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned DUR_CHOMP    = 48999548,
  parameter int unsigned DUR_PLACE    = 75483200,
  parameter int unsigned DUR_TRAVEL   = 197946892,
  parameter int unsigned DUR_MOVE     = 96002760,
  parameter int unsigned DUR_GAMEOVER = 320993010,
  parameter int unsigned GAP_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       stop,
  output logic       play,
  output logic [2:0] soundchoice,
  output logic       busy,
  output logic       done,
  output logic [4:0] pending
);

  localparam logic [31:0] GAP_LOAD = (GAP_CYCLES == 0) ? 32'd0 : GAP_CYCLES - 32'd1;
  localparam logic        GAP_ON   = (GAP_CYCLES != 0);

  // Timer load value for a sound: the START cycle counts as the first one.
  function automatic logic [31:0] dur_load(input sound_id_t id);
    case (id)
      SND_CHOMP:    dur_load = DUR_CHOMP - 32'd1;
      SND_PLACE:    dur_load = DUR_PLACE - 32'd1;
      SND_TRAVEL:   dur_load = DUR_TRAVEL - 32'd1;
      SND_MOVE:     dur_load = DUR_MOVE - 32'd1;
      SND_GAMEOVER: dur_load = DUR_GAMEOVER - 32'd1;
      default:      dur_load = 32'd0;
    endcase
  endfunction

  state_t      state_q;
  sound_id_t   cur_q;          // sound playing now, or last played in GAP
  sound_id_t   choice_q;
  logic        play_q, busy_q, done_q;
  logic [4:0]  pending_q, pending_d;

  sound_id_t   sel_id;
  logic        launch, finish, gap_end;
  logic        timer_load, timer_en, timer_zero;
  logic [31:0] timer_value;

  // Next-step decisions shared by the FSM and the timer.
  always_comb begin
    // NOTE: every output gets a value before any condition so no latch is
    // inferred on paths that skip an assignment.
    sel_id      = highest_pending(pending_q);
    launch      = 1'b0;
    finish      = 1'b0;
    gap_end     = 1'b0;
    timer_load  = 1'b0;
    timer_value = GAP_LOAD;
    timer_en    = (state_q != ST_IDLE);
    pending_d   = 5'b00000;
    if (!stop) begin
      if (sel_id != SND_NONE) begin
        if (state_q == ST_IDLE) begin
          launch = 1'b1;
        end else if ((state_q == ST_PLAYING || state_q == ST_GAP) &&
                     (sound_rank(sel_id) > sound_rank(cur_q))) begin
          launch = 1'b1;
        end
      end
      finish  = !launch && timer_zero &&
                (state_q == ST_START || state_q == ST_PLAYING);
      gap_end = !launch && timer_zero && (state_q == ST_GAP);
      timer_load = launch || (finish && GAP_ON);
      if (launch) begin
        timer_value = dur_load(sel_id);
      end
      // A request arriving with its own launch is absorbed by the clear.
      pending_d = (pending_q | req) & ~(launch ? sound_mask(sel_id) : 5'b00000);
    end
  end

  sound_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .en    (timer_en),
    .zero  (timer_zero)
  );

  // Scheduler FSM with registered player-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= SND_NONE;
      choice_q  <= SND_NONE;
      play_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 5'b00000;
    end else begin
      play_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= pending_d;
      if (stop) begin
        state_q  <= ST_IDLE;
        cur_q    <= SND_NONE;
        choice_q <= SND_NONE;
        busy_q   <= 1'b0;
      end else if (launch) begin
        state_q  <= ST_START;
        cur_q    <= sel_id;
        choice_q <= sel_id;
        play_q   <= 1'b1;
        busy_q   <= 1'b1;
      end else if (finish) begin
        done_q   <= 1'b1;
        choice_q <= SND_NONE;
        state_q  <= GAP_ON ? ST_GAP : ST_IDLE;
        busy_q   <= GAP_ON;
      end else if (gap_end) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (state_q == ST_START) begin
        state_q <= ST_PLAYING;
      end
    end
  end

  assign play        = play_q;
  assign soundchoice = choice_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pending     = pending_q;

endmodule
